// File: rtl/clock_divider_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_arbiter
// Description : Shares one clock_divider among four requesters. A round-robin
//               arbiter picks a requester, loads its divider value, waits a
//               settle period and then grants ownership. On every handover the
//               divided clock is parked low before the divider is stopped, so
//               owners never see a runt pulse. An owner that has held the
//               clock for MAX_HOLD cycles is preempted when another requester
//               is waiting.
//
// Ports       : clk_in   - system clock (only clock of the block)
//               reset    - synchronous active-low reset
//               req      - per-requester level request
//               div_req  - packed divider values, lane i = [16i+15:16i]
//               clk_div  - divided clock fed back from clock_divider
//               divider  - divider value driven to clock_divider (0 = stop)
//               grant    - one-hot ownership, zero when unowned
//               busy     - high whenever the arbiter is not idle
//               err_zero - pulse when a request is ignored for a zero divider
//
// Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_arbiter #(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned MAX_HOLD   = 1024
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [63:0] div_req,
    input  logic        clk_div,
    output logic [15:0] divider,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        err_zero
);

    localparam int unsigned c_set_w = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned c_ten_w = $clog2(MAX_HOLD + 1);
    localparam logic [c_set_w-1:0] c_settle_load = c_set_w'(SETTLE_CYC - 1);
    localparam logic [c_ten_w-1:0] c_max_hold    = c_ten_w'(MAX_HOLD);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_OWN    = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    state_t               r_state;
    logic [1:0]           r_owner;
    logic [1:0]           r_rr;
    logic [15:0]          r_divider;
    logic [3:0]           r_grant;
    logic [c_set_w-1:0]   r_settle;
    logic [c_ten_w-1:0]   r_tenure;
    logic                 r_err;

    state_t               w_state_nxt;
    logic [1:0]           w_owner_nxt;
    logic [1:0]           w_rr_nxt;
    logic [15:0]          w_div_nxt;
    logic [3:0]           w_grant_nxt;
    logic [c_set_w-1:0]   w_settle_nxt;
    logic [c_ten_w-1:0]   w_tenure_nxt;
    logic                 w_err_nxt;

    logic [3:0]           w_zero;
    logic [3:0]           w_valid;
    logic [1:0]           w_pick;
    logic                 w_any;
    logic                 w_others;
    logic [15:0]          w_owner_div;

    // A request only competes when it carries a usable (nonzero) divider.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_valid
            assign w_zero[gi]  = (div_req[16*gi +: 16] == 16'd0);
            assign w_valid[gi] = req[gi] & ~w_zero[gi];
        end
    endgenerate

    assign w_any       = |w_valid;
    assign w_others    = |(w_valid & ~(4'b0001 << r_owner));
    assign w_owner_div = div_req[{r_owner, 4'b0000} +: 16];

    // Round-robin pick: scan from the furthest offset back to the pointer so
    // the last hit, i.e. the one closest at-or-after r_rr, wins.
    always_comb begin
        w_pick = r_rr;
        for (int k = 3; k >= 0; k--) begin
            if (w_valid[r_rr + 2'(k)]) begin
                w_pick = r_rr + 2'(k);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_nxt     = r_rr;
        w_div_nxt    = r_divider;
        w_grant_nxt  = r_grant;
        w_settle_nxt = r_settle;
        w_tenure_nxt = r_tenure;
        w_err_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_div_nxt   = 16'd0;
                w_grant_nxt = 4'd0;
                w_err_nxt   = |(req & w_zero);
                if (w_any) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // The divider value is frozen here; later div_req changes
                // cannot disturb the clock the owner is about to receive.
                w_div_nxt    = w_owner_div;
                w_settle_nxt = c_settle_load;
                w_state_nxt  = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (r_settle == '0) begin
                    w_grant_nxt  = 4'b0001 << r_owner;
                    w_tenure_nxt = '0;
                    w_state_nxt  = ST_OWN;
                end else begin
                    w_settle_nxt = r_settle - 1'b1;
                end
            end

            ST_OWN: begin
                if (r_tenure != c_max_hold) begin
                    w_tenure_nxt = r_tenure + 1'b1;
                end
                // Release takes precedence; preemption reaches the same place.
                if (!req[r_owner]) begin
                    w_grant_nxt = 4'd0;
                    w_state_nxt = ST_DRAIN;
                end else if ((r_tenure == c_max_hold) && w_others) begin
                    w_grant_nxt = 4'd0;
                    w_state_nxt = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Stop the divider only while its output is low so the
                // divided clock parks low without a runt high phase.
                if (!clk_div) begin
                    w_div_nxt   = 16'd0;
                    w_rr_nxt    = r_owner + 2'd1;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_div_nxt   = 16'd0;
                w_grant_nxt = 4'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= 2'd0;
            r_rr      <= 2'd0;
            r_divider <= 16'd0;
            r_grant   <= 4'd0;
            r_settle  <= '0;
            r_tenure  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_rr      <= w_rr_nxt;
            r_divider <= w_div_nxt;
            r_grant   <= w_grant_nxt;
            r_settle  <= w_settle_nxt;
            r_tenure  <= w_tenure_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign divider  = r_divider;
    assign grant    = r_grant;
    assign busy     = (r_state != ST_IDLE);
    assign err_zero = r_err;

endmodule
`default_nettype wire
